top_ntt_mont_reduce_pipe: RTL and testbench

//  Pipelined Montgomery reducer for the Dilithium NTT datapath. Sits directly downstream of the
//  32x32->64 unsigned butterfly multiplier: takes the 64-bit product a and returns a*2^-32 mod Q
//  in [0,Q). Three-stage pipeline with valid/ready handshake and a tag carried alongside
//  (coefficient index) so the butterfly scheduler can route results.

---
 rtl/top_ntt_mont_reduce_pipe.sv | 116 +++++++++++
 tb/tb_top_ntt_mont_reduce_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_ntt_mont_reduce_pipe.sv
// Pipelined Montgomery reducer: 64-bit product a -> a*2^-32 mod Q in [0,Q), tag carried alongside.
// Latency 3 cycles accept->out_valid, one result per cycle. MONT_RANGE_CHECK_EN adds sticky range_err.
// Backpressure: single global advance enable; out_valid&!out_ready freezes every stage and drops in_ready.
module top_ntt_mont_reduce_pipe #(
  parameter logic [31:0] Q        = 32'd8380417,
  parameter logic [31:0] QNEG_INV = 32'd4236238847,
  parameter int          DIN_W    = 64,
  parameter int          DOUT_W   = 32,
  parameter int          TAG_W    = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIN_W-1:0]  in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DOUT_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
`ifdef MONT_RANGE_CHECK_EN
  output logic              range_err,
`endif
  output logic              busy
);

  typedef struct packed {
    logic [63:0]      a;
    logic [31:0]      t;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [64:0]      s;
    logic [TAG_W-1:0] tag;
  } s2_t;

  logic             r_v1;
  logic             r_v2;
  logic             r_v3;
  s1_t              r_s1;
  s2_t              r_s2;
  logic [31:0]      r_out_data;
  logic [TAG_W-1:0] r_out_tag;

  logic             w_en;
  logic             w_accept;
  logic [31:0]      w_t1;
  logic [64:0]      w_s2;
  logic [32:0]      w_r;
  logic             w_ge;
  logic [31:0]      w_res;

  assign w_en     = !r_v3 | out_ready;
  assign w_accept = in_valid & w_en;

  // Only the low 32 bits of a*QNEG_INV matter: t makes a + t*Q divisible by 2^32.
  assign w_t1 = in_data[31:0] * QNEG_INV;
  assign w_s2 = {1'b0, r_s1.a} + (65'(r_s1.t) * 65'(Q));

  // The quotient is below 2Q for legal inputs, so one conditional subtract finishes the reduction.
  assign w_r   = 33'(r_s2.s >> 32);
  assign w_ge  = (w_r >= {1'b0, Q});
  assign w_res = w_ge ? 32'(w_r - {1'b0, Q}) : w_r[31:0];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_v3       <= 1'b0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_out_data <= '0;
      r_out_tag  <= '0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (in_valid) begin
        r_s1.a   <= in_data;
        r_s1.t   <= w_t1;
        r_s1.tag <= in_tag;
      end
      if (r_v1) begin
        r_s2.s   <= w_s2;
        r_s2.tag <= r_s1.tag;
      end
      if (r_v2) begin
        r_out_data <= w_res;
        r_out_tag  <= r_s2.tag;
      end
    end
  end

`ifdef MONT_RANGE_CHECK_EN
  logic r_range_err;

  // a >= Q*2^32 reduces to a compare on the upper word since Q*2^32 has a zero low word.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_range_err <= 1'b0;
    end else if (w_accept && (in_data[63:32] >= Q)) begin
      r_range_err <= 1'b1;
    end
  end

  assign range_err = r_range_err;
`endif

  assign in_ready  = w_en;
  assign out_valid = r_v3;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign busy      = r_v1 | r_v2 | r_v3;

endmodule

// File: tb/tb_top_ntt_mont_reduce_pipe.sv
// Directed-vector bench for the Montgomery reducer pipeline, with a queue scoreboard for streaming.
module tb_top_ntt_mont_reduce_pipe;

  localparam int unsigned QV = 32'd8380417;
  localparam longint unsigned QL = 64'd8380417;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_tag;
  logic        busy;
`ifdef MONT_RANGE_CHECK_EN
  logic        range_err;
`endif

  top_ntt_mont_reduce_pipe dut (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
`ifdef MONT_RANGE_CHECK_EN
    .range_err (range_err),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [7:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t            vecs[9];
  int              n_checks;
  int              n_fail;
  longint unsigned rinv;
  logic            mon_en;
  logic            will_accept;
  int              emit_cnt;
  logic [39:0]     sb_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: (a mod Q) * (2^-32 mod Q) mod Q, with 2^-32 built from the inverse of 2.
  function automatic logic [31:0] gold(input logic [63:0] a);
    longint unsigned av;
    longint unsigned m;
    av = a;
    m  = ((av % QL) * rinv) % QL;
    return m[31:0];
  endfunction

  function automatic logic [63:0] rand_legal();
    logic [31:0] hi;
    logic [31:0] lo;
    hi = $urandom_range(QV - 1, 0);
    lo = $urandom;
    if ($urandom_range(7, 0) == 0) begin
      hi = QV - 1;
      lo = 32'hFFFF_FFFF;
    end
    return {hi, lo};
  endfunction

  // Monitor samples mid-cycle: records accepts/emits that the next rising edge will perform.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_dat;
    logic [7:0]  prev_tag;
    logic [39:0] front;
    prev_stall = 1'b0;
    prev_dat   = '0;
    prev_tag   = '0;
    forever begin
      @(negedge clk);
      will_accept = in_valid && in_ready;
      if (mon_en) begin
        chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
        if (prev_stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, prev_dat);
          chk("stall_tag", out_tag, prev_tag);
        end
        if (in_valid && in_ready) sb_q.push_back({in_tag, gold(in_data)});
        if (out_valid && out_ready) begin
          emit_cnt++;
          if (sb_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            front = sb_q.pop_front();
            chk("stream_data", out_data, front[31:0]);
            chk("stream_tag", out_tag, front[39:32]);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_dat   = out_data;
        prev_tag   = out_tag;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic apply_vec(input int i);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = vecs[i].a;
    in_tag   = vecs[i].tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("vec_busy_after_accept", busy, 1);
    @(posedge clk); #1;
    chk("vec_early_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("vec_valid", out_valid, 1);
    chk("vec_data", out_data, vecs[i].exp);
    chk("vec_tag", out_tag, vecs[i].tag);
    @(posedge clk); #1;
    chk("vec_drained_valid", out_valid, 0);
    chk("vec_drained_busy", busy, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    logic [63:0] a_b;
    logic [63:0] a_c;
    logic [63:0] a_d;
    int          k;
    n_checks    = 0;
    n_fail      = 0;
    mon_en      = 1'b0;
    will_accept = 1'b0;
    emit_cnt    = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    in_data     = 64'h1_0000_0000;
    in_tag      = 8'hAA;
    out_ready   = 1'b1;

    rinv = 1;
    repeat (32) rinv = (rinv * ((QL + 1) / 2)) % QL;

    vecs[0] = '{64'h1_0000_0000,           8'h11, 32'd1};
    vecs[1] = '{64'd8380417,               8'h22, 32'd0};
    vecs[2] = '{{32'd8380416, 32'd0},      8'h33, 32'd8380416};
    vecs[3] = '{64'd0,                     8'h44, 32'd0};
    vecs[4] = '{64'd1,                     8'h55, 32'd8265825};
    vecs[5] = '{64'd2,                     8'h66, 32'd8151233};
    vecs[6] = '{{32'd5, 32'd0},            8'h77, 32'd5};
    vecs[7] = '{{32'd1, 32'd1},            8'h88, 32'd8265826};
    vecs[8] = '{{32'd8380416, 32'hFFFF_FFFF}, 8'h99, 32'd114592};

    // Reset held with traffic offered: nothing may leak out.
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tag", out_tag, 0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    for (int i = 0; i < 9; i++) apply_vec(i);

    // Stall: fill the pipe with out_ready low, hold, then release with a simultaneous accept.
    a_b = rand_legal();
    a_c = rand_legal();
    a_d = rand_legal();
    mon_en = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h1_0000_0000;
    in_tag    = 8'hA0;
    @(posedge clk); #1;
    in_data = a_b;
    in_tag  = 8'hA1;
    @(posedge clk); #1;
    in_data = a_c;
    in_tag  = 8'hA2;
    @(posedge clk); #1;
    in_data = a_d;
    in_tag  = 8'hA3;
    chk("stall_in_ready", in_ready, 0);
    chk("stall_first_data", out_data, 1);
    chk("stall_first_tag", out_tag, 8'hA0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_hold_in_ready", in_ready, 0);
      chk("stall_hold_busy", busy, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Back-to-back stream at full rate.
    emit_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = rand_legal();
      in_tag   = 8'(i);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("full_rate_count", emit_cnt, 1000);
    drain();

    // Random valid and ready.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(1, 0));
      if (!in_valid || will_accept) begin
        if ($urandom_range(1, 0) == 1) begin
          in_valid = 1'b1;
          in_data  = rand_legal();
          in_tag   = 8'(i);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b1;
    k = 0;
    while (in_valid && k < 50) begin
      @(posedge clk); #1;
      if (will_accept) in_valid = 1'b0;
      k++;
    end
    chk("random_last_accepted", in_valid, 0);
    drain();
    mon_en = 1'b0;

    // Reset mid-flight discards work in progress.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 64'h7_0000_0000;
    in_tag   = 8'hC0;
    @(posedge clk); #1;
    in_tag   = 8'hC1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("midrst_no_leak", out_valid, 0);
    end

`ifdef MONT_RANGE_CHECK_EN
    chk("range_err_reset", range_err, 0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = {QV, 32'd0};
    in_tag   = 8'hE0;
    chk("range_err_before", range_err, 0);
    @(posedge clk); #1;
    in_data = {32'd5, 32'd0};
    in_tag  = 8'hE1;
    chk("range_err_set", range_err, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("range_err_sticky", range_err, 1);
    end
    rst_n = 1'b0;
    #1;
    chk("range_err_cleared", range_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
